// File: rtl/partition_kv_sender.sv
// Partitioner-side transmitter: buffers <key,value> points and hands them to the reducer arbiter one at a time.
// Latency: push->request 2 cycles when idle; ack at edge T -> slice k on o_value_data in cycle T+2+k.
// Backpressure: o_kv_ready drops while the FIFO holds FIFO_DEPTH points; KV_SENDER_STATS_EN adds o_sent_count.
module partition_kv_sender #(
    parameter int PRECISION       = 16,
    parameter int DIMENSION       = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           i_kv_valid,
    output logic                           o_kv_ready,
    input  logic [15:0]                    i_key,
    input  logic [PRECISION*DIMENSION-1:0] i_value,
    output logic                           o_request,
    input  logic                           i_acknowledged,
    output logic [15:0]                    o_key_data,
    output logic [PRECISION-1:0]           o_value_data,
    output logic                           o_busy,
    output logic                           o_empty
`ifdef KV_SENDER_STATS_EN
    ,
    output logic [31:0]                    o_sent_count
`endif
);

    localparam int VW = PRECISION * DIMENSION;
    localparam int CW = $clog2(DIMENSION) + 1;

    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]              BEAT_ONE  = 1;
    localparam logic [CW-1:0]              BEAT_LAST = CW'(DIMENSION - 1);

    typedef struct packed {
        logic [15:0]   key;
        logic [VW-1:0] value;
    } kv_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    kv_t                      mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    kv_t                        head;

    // Ready is purely a function of the stored count, so a same-cycle pop cannot lift it.
    assign o_kv_ready = (count_q != CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = i_kv_valid && o_kv_ready;
    assign head       = mem_q[rd_ptr_q];
    assign o_empty    = fifo_empty;

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the count, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{key: i_key, value: i_value};
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic           request_q, request_d;
    logic [CW-1:0]  beat_q, beat_d;
    kv_t            hold_q, hold_d;
    logic           last_beat;

    assign last_beat = (beat_q == BEAT_LAST);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one point per request, fixed GAP slot, then DIMENSION beats
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty)     state_d = ST_REQ;
            ST_REQ:  if (i_acknowledged)  state_d = ST_GAP;
            ST_GAP:                       state_d = ST_SEND;
            ST_SEND: if (last_beat)       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Per-state control: pop into the hold regs, request edges, beat counting
    always_comb begin
        pop       = 1'b0;
        request_d = request_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    hold_d    = head;
                    request_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Dropping request right after the ack keeps the arbiter from granting twice
                if (i_acknowledged) begin
                    request_d = 1'b0;
                end
            end
            ST_SEND: begin
                beat_d = last_beat ? '0 : beat_q + BEAT_ONE;
            end
            default: begin
                beat_d = beat_q;
            end
        endcase
    end

    // Registered request, beat counter and hold registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            request_q <= 1'b0;
            beat_q    <= '0;
            hold_q    <= '0;
        end else begin
            request_q <= request_d;
            beat_q    <= beat_d;
            hold_q    <= hold_d;
        end
    end

    // Value lane: slice 0 everywhere except SEND, where the beat counter picks the slice
    always_comb begin
        o_value_data = hold_q.value[PRECISION-1:0];
        if (state_q == ST_SEND) begin
            for (int k = 0; k < DIMENSION; k++) begin
                if (beat_q == CW'(k)) begin
                    o_value_data = hold_q.value[k*PRECISION +: PRECISION];
                end
            end
        end
    end

    assign o_request  = request_q;
    assign o_key_data = hold_q.key;
    assign o_busy     = (state_q != ST_IDLE);

`ifdef KV_SENDER_STATS_EN
    logic [31:0] sent_count_q;

    // Completed-transfer counter, bumped on the SEND->IDLE edge and wrapping at 2^32
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sent_count_q <= '0;
        end else if ((state_q == ST_SEND) && last_beat) begin
            sent_count_q <= sent_count_q + 32'd1;
        end
    end

    assign o_sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_partition_kv_sender.sv
// Bench for partition_kv_sender: directed tables and sequences plus random traffic against a queue-based model.
// Latency: model is advanced once per clock, outputs compared on the falling edge.
// Backpressure: pushes are accepted only when the model FIFO has room, mirroring o_kv_ready.
module tb_partition_kv_sender;

    localparam int P   = 16;
    localparam int DIM = 2;
    localparam int DEP = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        kv_valid;
    logic        kv_ready;
    logic [15:0] key;
    logic [31:0] value;
    logic        request;
    logic        ack;
    logic [15:0] key_data;
    logic [15:0] value_data;
    logic        busy;
    logic        empty;
`ifdef KV_SENDER_STATS_EN
    logic [31:0] sent_count;
`endif

    partition_kv_sender #(
        .PRECISION(P), .DIMENSION(DIM), .FIFO_DEPTH(DEP), .FIFO_ADDR_WIDTH(2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_kv_valid     (kv_valid),
        .o_kv_ready     (kv_ready),
        .i_key          (key),
        .i_value        (value),
        .o_request      (request),
        .i_acknowledged (ack),
        .o_key_data     (key_data),
        .o_value_data   (value_data),
        .o_busy         (busy),
        .o_empty        (empty)
`ifdef KV_SENDER_STATS_EN
        ,
        .o_sent_count   (sent_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: -1 idle, 0 requesting, 1 gap slot, 2..DIM+1 data beats
    typedef struct packed {
        logic [15:0] key;
        logic [31:0] val;
    } pt_t;

    pt_t         mq[$];
    pt_t         m_hold;
    int          m_phase;
    int unsigned m_sent;

    function automatic logic [15:0] m_value();
        int idx;
        idx = (m_phase >= 2) ? (m_phase - 2) : 0;
        return 16'(m_hold.val >> (idx * P));
    endfunction

    task automatic m_reset();
        mq.delete();
        m_hold  = '0;
        m_phase = -1;
        m_sent  = 0;
    endtask

    task automatic m_step(input bit v, input pt_t pin, input bit a, output bit accepted);
        accepted = v && (mq.size() != DEP);
        if (m_phase == -1) begin
            if (mq.size() > 0) begin
                m_hold  = mq.pop_front();
                m_phase = 0;
            end
        end else if (m_phase == 0) begin
            if (a) m_phase = 1;
        end else begin
            m_phase++;
            if (m_phase == DIM + 2) begin
                m_phase = -1;
                m_sent++;
            end
        end
        if (accepted) mq.push_back(pin);
    endtask

    task automatic cmp_model();
        chk("m_request", 32'(request),    32'(m_phase == 0));
        chk("m_busy",    32'(busy),       32'(m_phase != -1));
        chk("m_key",     32'(key_data),   32'(m_hold.key));
        chk("m_value",   32'(value_data), 32'(m_value()));
        chk("m_ready",   32'(kv_ready),   32'(mq.size() != DEP));
        chk("m_empty",   32'(empty),      32'(mq.size() == 0));
`ifdef KV_SENDER_STATS_EN
        chk("m_sent",    sent_count,      m_sent);
`endif
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic tick(input bit v, input logic [15:0] k, input logic [31:0] val, input bit a,
                        output bit accepted);
        pt_t p;
        kv_valid = v;
        key      = k;
        value    = val;
        ack      = a;
        p.key    = k;
        p.val    = val;
        m_step(v, p, a, accepted);
        @(posedge clock);
        @(negedge clock);
        cmp_model();
    endtask

    task automatic do_reset();
        kv_valid = 1'b0;
        key      = '0;
        value    = '0;
        ack      = 1'b0;
        reset_n  = 1'b0;
        m_reset();
        #1;
        chk("rst_request", 32'(request),    32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_key",     32'(key_data),   32'd0);
        chk("rst_value",   32'(value_data), 32'd0);
        chk("rst_empty",   32'(empty),      32'd1);
        chk("rst_ready",   32'(kv_ready),   32'd1);
`ifdef KV_SENDER_STATS_EN
        chk("rst_sent",    sent_count,      32'd0);
`endif
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        bit acc;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_phase == -1 && mq.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick(1'b0, 16'h0, 32'h0, m_phase == 0, acc);
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    typedef struct {
        bit          v;
        logic [15:0] k;
        logic [31:0] val;
        bit          a;
        bit          e_req;
        bit          e_busy;
        logic [15:0] e_key;
        logic [15:0] e_val;
        bit          e_rdy;
        bit          e_empty;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          nacc;
        int          nreq;
        int          cyc;
        int          rises[$];
        bit          prev_req;
        logic [31:0] v2;

        // single transfer: request once, then gap slot and two beats
        tbl[0] = '{1, 16'h0005, 32'hBBBB_AAAA, 0,  0, 0, 16'h0000, 16'h0000, 1, 0};
        tbl[1] = '{0, 16'h0000, 32'h0,         0,  1, 1, 16'h0005, 16'hAAAA, 1, 1};
        tbl[2] = '{0, 16'h0000, 32'h0,         1,  0, 1, 16'h0005, 16'hAAAA, 1, 1};
        tbl[3] = '{0, 16'h0000, 32'h0,         0,  0, 1, 16'h0005, 16'hAAAA, 1, 1};
        tbl[4] = '{0, 16'h0000, 32'h0,         0,  0, 1, 16'h0005, 16'hBBBB, 1, 1};
        tbl[5] = '{0, 16'h0000, 32'h0,         0,  0, 0, 16'h0005, 16'hAAAA, 1, 1};

        reset_n = 1'b1;
        @(negedge clock);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            tick(tbl[i].v, tbl[i].k, tbl[i].val, tbl[i].a, acc);
            chk($sformatf("t1_req[%0d]", i),   32'(request),    32'(tbl[i].e_req));
            chk($sformatf("t1_busy[%0d]", i),  32'(busy),       32'(tbl[i].e_busy));
            chk($sformatf("t1_key[%0d]", i),   32'(key_data),   32'(tbl[i].e_key));
            chk($sformatf("t1_val[%0d]", i),   32'(value_data), 32'(tbl[i].e_val));
            chk($sformatf("t1_rdy[%0d]", i),   32'(kv_ready),   32'(tbl[i].e_rdy));
            chk($sformatf("t1_empty[%0d]", i), 32'(empty),      32'(tbl[i].e_empty));
        end

        // ack withheld for five cycles
        v2 = 32'h1234_9876;
        tick(1'b1, 16'h0777, v2, 1'b0, acc);
        tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
        nreq = 32'(request);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
            nreq += 32'(request);
            chk("t2_key_hold", 32'(key_data), 32'h0777);
        end
        chk("t2_req_cycles", nreq, 6);
        tick(1'b0, 16'h0, 32'h0, 1'b1, acc);
        chk("t2_req_drop", 32'(request),    32'd0);
        chk("t2_gap_val",  32'(value_data), 32'h9876);
        tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
        chk("t2_beat0",    32'(value_data), 32'h9876);
        tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
        chk("t2_beat1",    32'(value_data), 32'h1234);
        tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
        chk("t2_idle",     32'(busy),       32'd0);

        // no ack: FIFO plus hold register absorb five points
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 16'h0300 + 16'(nacc), 32'h00A0_0000 + 32'(nacc), 1'b0, acc);
            nacc += int'(acc);
        end
        chk("t3_accepted", nacc, 5);
        chk("t3_full",     32'(kv_ready), 32'd0);
        tick(1'b1, 16'h0300 + 16'(nacc), 32'h00A0_0000 + 32'(nacc), 1'b1, acc);
        nacc += int'(acc);
        for (int i = 0; i < 20 && nacc < 6; i++) begin
            tick(1'b1, 16'h0300 + 16'(nacc), 32'h00A0_0000 + 32'(nacc), 1'b0, acc);
            nacc += int'(acc);
        end
        chk("t3_sixth", nacc, 6);
        drain();

        // back-to-back points with ack tied to request
        do_reset();
        cyc      = 0;
        prev_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i < 3) tick(1'b1, 16'h0400 + 16'(i), 32'hC000_0000 + 32'(i * 3), request, acc);
            else       tick(1'b0, 16'h0, 32'h0, request, acc);
            cyc++;
            if (request && !prev_req) begin
                rises.push_back(cyc);
                if (rises.size() == 3) chk("t4_empty_after_pop3", 32'(empty), 32'd1);
            end
            prev_req = request;
            if (rises.size() == 3 && m_phase == -1) break;
        end
        chk("t4_rises", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("t4_spacing0", rises[1] - rises[0], 5);
            chk("t4_spacing1", rises[2] - rises[1], 5);
        end
        drain();
`ifdef KV_SENDER_STATS_EN
        chk("t6_sent3", sent_count, 32'd3);
        tick(1'b0, 16'h0, 32'h0, 1'b1, acc);
        chk("t6_spurious", sent_count, 32'd3);
        chk("t6_busy",     32'(busy),  32'd0);
`endif

        // reset during the first data beat
        tick(1'b1, 16'h0555, 32'h5555_6666, 1'b0, acc);
        for (int i = 0; i < 10 && m_phase != 2; i++) begin
            tick(1'b0, 16'h0, 32'h0, m_phase == 0, acc);
        end
        chk("t5_in_beat0", 32'(value_data), 32'h6666);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
            chk("t5_stays_idle", 32'(busy), 32'd0);
        end
        tick(1'b1, 16'h0556, 32'h7777_8888, 1'b0, acc);
        tick(1'b0, 16'h0, 32'h0, 1'b0, acc);
        chk("t5_new_request", 32'(request), 32'd1);
        drain();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit a;
            a = (request && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 9) == 0);
            tick($urandom_range(0, 1) == 1, 16'($urandom), $urandom, a, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
